// File: rtl/apb2_master.sv
// APB2 initiator: single valid/ready commands -> SETUP/ACCESS transfers, one-cycle response strobe.
// Optional APB2_MASTER_BACK2BACK_EN: accept the next command in the final ACCESS cycle (no IDLE gap).
module apb2_master #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCESS_WAIT = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  if (ACCESS_WAIT < 0 || ACCESS_WAIT > 3) begin : g_bad_wait
    $error("apb2_master: ACCESS_WAIT must be in 0..3");
  end

  localparam logic [1:0] WAIT_LAST = 2'(ACCESS_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            wait_q, wait_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cmd_ready   = 1'b0;
    PSELx       = 1'b0;
    PENABLE     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        PSELx   = 1'b1;
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        if (wait_q == WAIT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          if (!pwrite_q) rsp_rdata_d = PRDATA;
          state_d = IDLE;
`ifdef APB2_MASTER_BACK2BACK_EN
          // Response for the finishing transfer coincides with the next SETUP.
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            state_d  = SETUP;
          end
`endif
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
